// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage bus: hazard/decode controls, imem port, IF/ID outputs
// Ports grouped here:
//   stall, br, npc, Dclr    : controls from hazard unit and D-stage decode
//   imem_addr / imem_rdata  : combinational instruction-memory port
//   instr_D, pc_D, pc8_D,
//   valid_D, fetch_cnt      : IF/ID register contents delivered to D
// master = fetch stage, slave = surrounding pipeline / memory.
interface fetch_stage_if;
    logic        stall;
    logic        br;
    logic [31:0] npc;
    logic        Dclr;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic [31:0] pc8_D;
    logic        valid_D;
    logic [31:0] fetch_cnt;

    modport master (
        input  stall, br, npc, Dclr, imem_rdata,
        output imem_addr, instr_D, pc_D, pc8_D, valid_D, fetch_cnt
    );

    modport slave (
        output stall, br, npc, Dclr, imem_rdata,
        input  imem_addr, instr_D, pc_D, pc8_D, valid_D, fetch_cnt
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction-fetch stage with IF/ID pipeline register
// Ports:
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-high reset
//   bus   : fetch_stage_if.master (controls in, imem port, IF/ID outputs)
module fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic        valid_d;
    logic [31:0] fetch_cnt;

    // Redirect targets are forced word-aligned; the low two bits of npc are dropped.
    logic [31:0] pc_next;
    assign pc_next = bus.br ? {bus.npc[31:2], 2'b00} : pc_f + 32'd4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f      <= PC_RESET;
            instr_d   <= NOP_WORD;
            pc_d      <= PC_RESET;
            valid_d   <= 1'b0;
            fetch_cnt <= 32'd0;
        end else if (!bus.stall) begin
            // Stall freezes everything, so a pending redirect/annul waits for release.
            pc_f <= pc_next;
            pc_d <= pc_f;
            if (bus.Dclr) begin
                // Annulled delay slot: bubble into D, not counted as delivered.
                instr_d <= NOP_WORD;
                valid_d <= 1'b0;
            end else begin
                instr_d   <= bus.imem_rdata;
                valid_d   <= 1'b1;
                fetch_cnt <= fetch_cnt + 32'd1;
            end
        end
    end

    assign bus.imem_addr = pc_f;
    assign bus.instr_D   = instr_d;
    assign bus.pc_D      = pc_d;
    assign bus.pc8_D     = pc_d + 32'd8;
    assign bus.valid_D   = valid_d;
    assign bus.fetch_cnt = fetch_cnt;
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Deterministic, address-dependent instruction memory.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0] ^ 16'h5a5a, a[31:16] ^ a[15:0]};
    endfunction

    assign bus.imem_rdata = imem(bus.imem_addr);

    // Reference model state.
    logic [31:0] m_pcf, m_instr, m_pcd, m_cnt;
    logic        m_valid;

    task automatic model_reset();
        m_pcf = 32'h3000; m_instr = 32'h0; m_pcd = 32'h3000; m_valid = 1'b0; m_cnt = 32'd0;
    endtask

    task automatic model_step(input logic s, input logic b, input logic c, input logic [31:0] n);
        logic [31:0] fetched_pc;
        if (!s) begin
            fetched_pc = m_pcf;
            m_pcf = b ? (n & 32'hFFFF_FFFC) : m_pcf + 32'd4;
            m_pcd = fetched_pc;
            if (c) begin
                m_instr = 32'h0;
                m_valid = 1'b0;
            end else begin
                m_instr = imem(fetched_pc);
                m_valid = 1'b1;
                m_cnt   = m_cnt + 32'd1;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pcf, input logic [31:0] ins,
                           input logic [31:0] pcd, input logic v, input logic [31:0] cnt);
        chk({tag, ".imem_addr"}, bus.imem_addr, pcf);
        chk({tag, ".instr_D"}, bus.instr_D, ins);
        chk({tag, ".pc_D"}, bus.pc_D, pcd);
        chk({tag, ".pc8_D"}, bus.pc8_D, pcd + 32'd8);
        chk({tag, ".valid_D"}, {31'd0, bus.valid_D}, {31'd0, v});
        chk({tag, ".fetch_cnt"}, bus.fetch_cnt, cnt);
    endtask

    task automatic step(input logic s, input logic b, input logic c, input logic [31:0] n);
        bus.stall = s; bus.br = b; bus.Dclr = c; bus.npc = n;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        stall;
        logic        br;
        logic        dclr;
        logic [31:0] npc;
        logic [31:0] pcd;
        logic        valid;
        logic [31:0] pcf;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl[17];

    initial begin
        logic [31:0] exp_instr;
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h3000,     1'b1, 32'h3004,     32'd1};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h3004,     1'b1, 32'h3008,     32'd2};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h3008,     1'b1, 32'h300C,     32'd3};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h300C,     1'b1, 32'h3010,     32'd4};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 32'h3100,      32'h3010,     1'b0, 32'h3100,     32'd4};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h3100,     1'b1, 32'h3104,     32'd5};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h3203,      32'h3104,     1'b1, 32'h3200,     32'd6};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h3200,     1'b1, 32'h3204,     32'd7};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h3040,      32'h3204,     1'b1, 32'h3040,     32'd8};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h3040,     1'b1, 32'h3044,     32'd9};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 32'h3200,      32'h3040,     1'b1, 32'h3044,     32'd9};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 32'h3200,      32'h3040,     1'b1, 32'h3044,     32'd9};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 32'h3200,      32'h3040,     1'b1, 32'h3044,     32'd9};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 32'h3200,      32'h3044,     1'b0, 32'h3200,     32'd9};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h3200,     1'b1, 32'hFFFF_FFFC, 32'd10};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'hFFFF_FFFC, 1'b1, 32'h0000_0000, 32'd11};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0000, 1'b1, 32'h0000_0004, 32'd12};

        bus.stall = 1'b0; bus.br = 1'b0; bus.Dclr = 1'b0; bus.npc = 32'h0;

        // Asynchronous reset, checked before any clock edge.
        #1 reset = 1'b1;
        #1;
        chk_all("reset", 32'h3000, 32'h0, 32'h3000, 1'b0, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();

        // Directed table: sequential fetch, redirects, annul, stall, alignment, wrap.
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].stall, tbl[i].br, tbl[i].dclr, tbl[i].npc);
            model_step(tbl[i].stall, tbl[i].br, tbl[i].dclr, tbl[i].npc);
            exp_instr = tbl[i].valid ? imem(tbl[i].pcd) : 32'h0;
            chk_all($sformatf("vec%0d", i), tbl[i].pcf, exp_instr, tbl[i].pcd, tbl[i].valid, tbl[i].cnt);
        end

        // Randomized run against the reference model.
        for (int i = 0; i < 300; i++) begin
            logic s, b, c;
            logic [31:0] n;
            s = ($urandom_range(3) == 0);
            b = ($urandom_range(3) == 0);
            c = ($urandom_range(5) == 0);
            n = $urandom;
            step(s, b, c, n);
            model_step(s, b, c, n);
            chk_all($sformatf("rnd%0d", i), m_pcf, m_instr, m_pcd, m_valid, m_cnt);
        end

        // Reset asserted between edges while stall/redirect/annul are pending.
        bus.stall = 1'b1; bus.br = 1'b1; bus.Dclr = 1'b1; bus.npc = 32'h1234_5678;
        #3 reset = 1'b1;
        #1;
        chk_all("midreset", 32'h3000, 32'h0, 32'h3000, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        chk_all("midreset_hold", 32'h3000, 32'h0, 32'h3000, 1'b0, 32'd0);
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk_all("restart", 32'h3004, imem(32'h3000), 32'h3000, 1'b1, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the five-stage MIPS pipeline. Holds the PC, drives the instruction-memory address, and latches the fetched word plus its PC into the D stage, where the main decode controller consumes it. Honours the hazard-unit stall, takes the branch/jump redirect resolved in D, and annuls the delay-slot instruction when D raises `Dclr` (branch-likely not taken).

## Interface
- `PC_RESET`, 32'h0000_3000, PC value after reset (first fetched address).
- `NOP_WORD`, 32'h0000_0000, word loaded into `instr_D` on reset or annul.

- `clk` in 1: sole clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `stall` in 1: from hazard unit; freezes PC and IF/ID register.
- `br` in 1: from D-stage decode; redirect PC to `npc` this cycle.
- `npc` in 32: branch/jump target computed in D.
- `Dclr` in 1: from D-stage decode; annul the instruction entering D.
- `imem_addr` out 32: current F-stage PC (combinational from PC register).
- `imem_rdata` in 32: instruction word at `imem_addr` (combinational memory).
- `instr_D` out 32: instruction in D stage.
- `pc_D` out 32: PC of `instr_D`.
- `pc8_D` out 32: `pc_D + 8` (link address for jal/jalr/bgezal).
- `valid_D` out 1: 1 when `instr_D` is a real fetched instruction, 0 for bubble/annul.
- `fetch_cnt` out 32: count of instructions delivered into D.

## Operation
- Registers: `pc_F` (32), `instr_D`, `pc_D`, `valid_D`, `fetch_cnt`. `pc8_D` is combinational from `pc_D`.
- `imem_addr = pc_F`.
- Next PC, evaluated each edge, priority high to low:
  - `stall=1`: `pc_F` holds.
  - `br=1`: `pc_F <= {npc[31:2], 2'b00}` (target forced word-aligned).
  - otherwise: `pc_F <= pc_F + 4`, wrap modulo 2^32.
- IF/ID register, priority high to low:
  - `stall=1`: `instr_D`, `pc_D`, `valid_D` hold; `Dclr` and `br` are ignored this cycle.
  - `Dclr=1`: `instr_D <= NOP_WORD`, `pc_D <= pc_F`, `valid_D <= 0`.
  - otherwise: `instr_D <= imem_rdata`, `pc_D <= pc_F`, `valid_D <= 1`.
- Delay slot: with `br=1`, the word currently in F (`pc_D+4`) still enters D unless `Dclr=1`. No delay-slot squash on an ordinary taken branch.
- `br` and `Dclr` together, no stall: PC redirects and the slot is annulled in the same edge.
- `fetch_cnt` increments by 1 on every edge where the IF/ID register loads with `valid_D <= 1`. It wraps 0xFFFF_FFFF -> 0. It does not count stalls or annuls.

## Timing
- Reset (asynchronous, takes effect without clock): `pc_F=PC_RESET`, `imem_addr=PC_RESET`, `instr_D=NOP_WORD`, `pc_D=PC_RESET`, `pc8_D=PC_RESET+8`, `valid_D=0`, `fetch_cnt=0`.
- First edge after reset deassertion: D holds the word at `PC_RESET`, and `pc_F=PC_RESET+4`.
- Fetch-to-D latency is 1 cycle. Redirect penalty is 0 extra cycles: the delay slot covers it, and the target is fetched on the cycle after `br`.
- `stall`, `br`, `npc` and `Dclr` are sampled only at the rising edge. `stall` may stay high for any number of cycles; the state is then frozen exactly.
- Reset asserted mid-stall or mid-redirect discards the pending redirect and annul. The block restarts at `PC_RESET`.

## Test plan
- Reset release, no stall, 4 edges -> `pc_D` = 0x3000, 0x3004, 0x3008, 0x300C; `valid_D=1`; `fetch_cnt=4`; `pc8_D=0x3014` after the 4th.
- With `pc_F=0x3008`, pulse `br=1`, `npc=0x3040` for 1 cycle -> next `pc_D=0x3008` (delay slot, `valid_D=1`); following `pc_D=0x3040`.
- `br=1`, `Dclr=1`, `npc=0x3100` together at `pc_F=0x3010` -> `instr_D=0`, `valid_D=0`, `pc_D=0x3010`; next `pc_D=0x3100`; `fetch_cnt` unchanged on the annul edge.
- Hold `stall=1` for 3 cycles with `br=1`, `Dclr=1`, `npc=0x3200` -> `pc_F`, `instr_D`, `pc_D`, `valid_D`, `fetch_cnt` unchanged; drop `stall` -> redirect and annul take effect on the next edge.
- `npc=0x3203` with `br=1` -> `pc_F=0x3200`. Preload via redirect to 0xFFFF_FFFC, then one step -> `pc_F=0x0000_0000`.
- Assert `reset` between clock edges mid-run -> all outputs reach reset values before the next edge; `fetch_cnt=0`.
